// File: rtl/ps2_sw_entry.sv
// PS/2 set-2 keyboard front end. Receives and validates frames, then
// decodes hex digit keys into the 12-bit switch-bank replacement word.
//
// Ports:
//   clk, rst          system clock, async active-low reset
//   ps2_clk, ps2_data raw asynchronous PS/2 lines
//   sw, sw_valid      committed word and its one-cycle update pulse
//   entry, digits     digits typed since last commit/clear, count 0..3
//   scan, scan_valid  last good scan byte and its one-cycle pulse
//   frame_err         one-cycle pulse on start/parity/stop/timeout error
module ps2_sw_entry #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] sw,
    output logic        sw_valid,
    output logic [11:0] entry,
    output logic [1:0]  digits,
    output logic [7:0]  scan,
    output logic        scan_valid,
    output logic        frame_err
);

    localparam int LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CW    = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronizers reset to 1 (idle bus) so no false edge after reset.
    logic [1:0] ck_sync;
    logic [1:0] dt_sync;
    logic       ck_prev;
    logic       fall;
    logic       bit_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_sync <= 2'b11;
            dt_sync <= 2'b11;
            ck_prev <= 1'b1;
        end else begin
            ck_sync <= {ck_sync[0], ps2_clk};
            dt_sync <= {dt_sync[0], ps2_data};
            ck_prev <= ck_sync[1];
        end
    end

    assign fall   = ck_prev & ~ck_sync[1];
    assign bit_in = dt_sync[1];

    // Receiver
    state_t        state, state_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_ok, par_ok_n;
    logic [CW-1:0] tcnt;
    logic          tmo;
    logic          byte_ok;
    logic          err;

    assign tmo = (state != IDLE) && (tcnt == LIM);

    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        shreg_n  = shreg;
        par_ok_n = par_ok;
        byte_ok  = 1'b0;
        err      = 1'b0;
        if (tmo) begin
            state_n = IDLE;
            err     = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_n = DATA;
                        bcnt_n  = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n = {bit_in, shreg[7:1]};
                    bcnt_n  = bcnt + 3'd1;
                    if (bcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = ^{shreg, bit_in};
                    state_n  = STOP;
                end
                STOP: begin
                    if (bit_in && par_ok) byte_ok = 1'b1;
                    else                  err     = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bcnt       <= 3'd0;
            shreg      <= 8'h00;
            par_ok     <= 1'b0;
            tcnt       <= '0;
            scan       <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            par_ok     <= par_ok_n;
            scan_valid <= byte_ok;
            frame_err  <= err;
            if (byte_ok) scan <= shreg;
            // Gap timer only runs inside a frame; each edge restarts it.
            if (state == IDLE || fall) tcnt <= '0;
            else                       tcnt <= tcnt + CW'(1);
        end
    end

    // Decoder
    function automatic logic [4:0] hex_of(input logic [7:0] c);
        logic [4:0] r;
        unique case (c)
            8'h45:   r = 5'h10;
            8'h16:   r = 5'h11;
            8'h1E:   r = 5'h12;
            8'h26:   r = 5'h13;
            8'h25:   r = 5'h14;
            8'h2E:   r = 5'h15;
            8'h36:   r = 5'h16;
            8'h3D:   r = 5'h17;
            8'h3E:   r = 5'h18;
            8'h46:   r = 5'h19;
            8'h1C:   r = 5'h1A;
            8'h32:   r = 5'h1B;
            8'h21:   r = 5'h1C;
            8'h23:   r = 5'h1D;
            8'h24:   r = 5'h1E;
            8'h2B:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [4:0] hx;
    logic       brk;
    logic       ext;

    assign hx = hex_of(scan);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw       <= 12'h000;
            sw_valid <= 1'b0;
            entry    <= 12'h000;
            digits   <= 2'd0;
            brk      <= 1'b0;
            ext      <= 1'b0;
        end else begin
            sw_valid <= 1'b0;
            if (scan_valid) begin
                if (scan == 8'hF0) begin
                    brk <= 1'b1;
                end else if (scan == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    // Prefix flags apply to exactly one following code.
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!brk && !ext) begin
                        if (hx[4]) begin
                            entry <= {entry[7:0], hx[3:0]};
                            if (digits != 2'd3) digits <= digits + 2'd1;
                        end else if (scan == 8'h5A) begin
                            sw       <= entry;
                            sw_valid <= 1'b1;
                            entry    <= 12'h000;
                            digits   <= 2'd0;
                        end else if (scan == 8'h66) begin
                            entry  <= 12'h000;
                            digits <= 2'd0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_sw_entry.sv
// Testbench for ps2_sw_entry: table of frames with expected state,
// plus directed timeout, start-bit and mid-frame reset sequences.
module tb_ps2_sw_entry;

    localparam int HALF  = 20;
    localparam int LIMIT = 10_000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] sw;
    logic        sw_valid;
    logic [11:0] entry;
    logic [1:0]  digits;
    logic [7:0]  scan;
    logic        scan_valid;
    logic        frame_err;

    ps2_sw_entry dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .sw         (sw),
        .sw_valid   (sw_valid),
        .entry      (entry),
        .digits     (digits),
        .scan       (scan),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int c_sv = 0;
    int c_swv = 0;
    int c_fe = 0;

    always @(negedge clk) begin
        if (scan_valid) c_sv  = c_sv + 1;
        if (sw_valid)   c_swv = c_swv + 1;
        if (frame_err)  c_fe  = c_fe + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic perr,
                              input logic bstop);
        pulse_bit(1'b0);
        for (int i = 0; i < 8; i++) pulse_bit(b[i]);
        pulse_bit(~^b ^ perr);
        pulse_bit(~bstop);
        ps2_data = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  code;
        logic        perr;
        logic        bstop;
        logic [7:0]  scan;
        logic [11:0] entry;
        logic [1:0]  digits;
        logic [11:0] sw;
        int          nsv;
        int          nswv;
        int          nfe;
    } vec_t;

    vec_t tbl[21];

    int sv0, swv0, fe0;

    initial begin
        tbl[0]  = '{8'h16, 0, 0, 8'h16, 12'h001, 2'd1, 12'h000, 1, 0, 0};
        tbl[1]  = '{8'h1E, 0, 0, 8'h1E, 12'h012, 2'd2, 12'h000, 1, 0, 0};
        tbl[2]  = '{8'h26, 0, 0, 8'h26, 12'h123, 2'd3, 12'h000, 1, 0, 0};
        tbl[3]  = '{8'h25, 0, 0, 8'h25, 12'h234, 2'd3, 12'h000, 1, 0, 0};
        tbl[4]  = '{8'h5A, 0, 0, 8'h5A, 12'h000, 2'd0, 12'h234, 1, 1, 0};
        tbl[5]  = '{8'h1C, 0, 0, 8'h1C, 12'h00A, 2'd1, 12'h234, 1, 0, 0};
        tbl[6]  = '{8'hF0, 0, 0, 8'hF0, 12'h00A, 2'd1, 12'h234, 1, 0, 0};
        tbl[7]  = '{8'h1C, 0, 0, 8'h1C, 12'h00A, 2'd1, 12'h234, 1, 0, 0};
        tbl[8]  = '{8'h32, 0, 0, 8'h32, 12'h0AB, 2'd2, 12'h234, 1, 0, 0};
        tbl[9]  = '{8'h16, 1, 0, 8'h32, 12'h0AB, 2'd2, 12'h234, 0, 0, 1};
        tbl[10] = '{8'h16, 0, 0, 8'h16, 12'hAB1, 2'd3, 12'h234, 1, 0, 0};
        tbl[11] = '{8'h16, 0, 1, 8'h16, 12'hAB1, 2'd3, 12'h234, 0, 0, 1};
        tbl[12] = '{8'h66, 0, 0, 8'h66, 12'h000, 2'd0, 12'h234, 1, 0, 0};
        tbl[13] = '{8'hE0, 0, 0, 8'hE0, 12'h000, 2'd0, 12'h234, 1, 0, 0};
        tbl[14] = '{8'h5A, 0, 0, 8'h5A, 12'h000, 2'd0, 12'h234, 1, 0, 0};
        tbl[15] = '{8'h5A, 0, 0, 8'h5A, 12'h000, 2'd0, 12'h000, 1, 1, 0};
        tbl[16] = '{8'h3D, 0, 0, 8'h3D, 12'h007, 2'd1, 12'h000, 1, 0, 0};
        tbl[17] = '{8'h3E, 0, 0, 8'h3E, 12'h078, 2'd2, 12'h000, 1, 0, 0};
        tbl[18] = '{8'h66, 0, 0, 8'h66, 12'h000, 2'd0, 12'h000, 1, 0, 0};
        tbl[19] = '{8'h46, 0, 0, 8'h46, 12'h009, 2'd1, 12'h000, 1, 0, 0};
        tbl[20] = '{8'h5A, 0, 0, 8'h5A, 12'h000, 2'd0, 12'h009, 1, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sw", 32'(sw), 32'h000);
        chk("rst_entry", 32'(entry), 32'h000);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_scan", 32'(scan), 32'h00);
        chk("rst_pulses", {29'd0, scan_valid, sw_valid, frame_err}, 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            sv0 = c_sv;
            swv0 = c_swv;
            fe0 = c_fe;
            send_frame(tbl[i].code, tbl[i].perr, tbl[i].bstop);
            chk($sformatf("v%0d_scan", i), 32'(scan), 32'(tbl[i].scan));
            chk($sformatf("v%0d_entry", i), 32'(entry), 32'(tbl[i].entry));
            chk($sformatf("v%0d_digits", i), 32'(digits),
                32'(tbl[i].digits));
            chk($sformatf("v%0d_sw", i), 32'(sw), 32'(tbl[i].sw));
            chk($sformatf("v%0d_nsv", i), 32'(c_sv - sv0), 32'(tbl[i].nsv));
            chk($sformatf("v%0d_nswv", i), 32'(c_swv - swv0),
                32'(tbl[i].nswv));
            chk($sformatf("v%0d_nfe", i), 32'(c_fe - fe0), 32'(tbl[i].nfe));
        end

        // Start bit of 1 on an idle bus.
        sv0 = c_sv;
        fe0 = c_fe;
        pulse_bit(1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("startbit_nfe", 32'(c_fe - fe0), 32'd1);
        chk("startbit_nsv", 32'(c_sv - sv0), 32'd0);

        // Truncated frame: start plus 3 data bits of 0x45, then silence.
        sv0 = c_sv;
        fe0 = c_fe;
        pulse_bit(1'b0);
        pulse_bit(1'b1);
        pulse_bit(1'b0);
        pulse_bit(1'b1);
        ps2_data = 1'b1;
        repeat (LIMIT + 200) @(posedge clk);
        #1;
        chk("tmo_nfe", 32'(c_fe - fe0), 32'd1);
        chk("tmo_nsv", 32'(c_sv - sv0), 32'd0);
        sv0 = c_sv;
        send_frame(8'h45, 1'b0, 1'b0);
        chk("tmo_next_scan", 32'(scan), 32'h45);
        chk("tmo_next_nsv", 32'(c_sv - sv0), 32'd1);
        chk("tmo_next_entry", 32'(entry), 32'h000);
        chk("tmo_next_digits", 32'(digits), 32'd1);
        chk("pre_rst_sw", 32'(sw), 32'h009);

        // Reset mid-frame during 0x3D.
        pulse_bit(1'b0);
        pulse_bit(1'b1);
        pulse_bit(1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_sw", 32'(sw), 32'h000);
        chk("arst_entry", 32'(entry), 32'h000);
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_scan", 32'(scan), 32'h00);
        chk("arst_pulses", {29'd0, scan_valid, sw_valid, frame_err}, 32'h0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sv0 = c_sv;
        fe0 = c_fe;
        send_frame(8'h16, 1'b0, 1'b0);
        chk("post_rst_scan", 32'(scan), 32'h16);
        chk("post_rst_entry", 32'(entry), 32'h001);
        chk("post_rst_digits", 32'(digits), 32'd1);
        chk("post_rst_sw", 32'(sw), 32'h000);
        chk("post_rst_nsv", 32'(c_sv - sv0), 32'd1);
        chk("post_rst_nfe", 32'(c_fe - fe0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
